// File: rtl/debug_pkg.sv
// Shared encodings for the debug run controller and the debug UART front end.
package debug_pkg;

   localparam int W_STEPS = 8;

   typedef enum logic [1:0] {
      OP_RUN     = 2'b00,
      OP_STEP    = 2'b01,
      OP_HALT    = 2'b10,
      OP_RESTART = 2'b11
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_STEP    = 2'b10,
      ST_RESTART = 2'b11
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_STEP  = 2'b01,
      CAUSE_BREAK = 2'b10,
      CAUSE_HALT  = 2'b11
   } stop_cause_t;

endpackage

// File: rtl/debug_run_controller_if.sv
// Debug-link command channel: strobe/ready handshake plus the illegal-command pulse.
interface debug_run_controller_if;
   import debug_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   cmd_op_t            cmd_op;
   logic [W_STEPS-1:0] cmd_steps;
   logic               cmd_err;

   modport master (output cmd_valid, cmd_op, cmd_steps, input cmd_ready, cmd_err);
   modport slave  (input cmd_valid, cmd_op, cmd_steps, output cmd_ready, cmd_err);

endinterface

// File: rtl/step_counter.sv
// STEP instruction down-counter with load, decrement and terminal-count flag.
module step_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   // High when the decrement in this cycle lands the count on 0.
   assign zero = ~|count_q[W-1:1];

endmodule

// File: rtl/debug_run_controller.sv
// Debug run/step/halt/restart sequencer driving the program-counter debug controls.
//   state      | meaning
//   ST_IDLE    | PC frozen, waiting for a command
//   ST_RUN     | PC free-running until breakpoint, end of program or HALT
//   ST_STEP    | PC enabled for the loaded number of instructions
//   ST_RESTART | single cycle with the PC held in reset
module debug_run_controller
   import debug_pkg::*;
#(
   parameter int W_ADDR = 8,
   parameter int W_CNT  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   debug_run_controller_if.slave cmd,
   input  logic [W_ADDR-1:0]     pc_addr,
   input  logic                  bp_en,
   input  logic [W_ADDR-1:0]     bp_addr,
   input  logic                  end_of_prog,
   output logic                  pc_enable,
   output logic                  pc_reset,
   output run_state_t            state,
   output logic [W_CNT-1:0]      cycle_count,
   output logic                  done,
   output stop_cause_t           stop_cause
);

   run_state_t         state_n;
   stop_cause_t        cause_n;
   logic               pc_enable_n, pc_reset_n, done_n, err_n, ready_n, first_n;
   logic               ready_q, err_q, first_q;
   logic [W_CNT-1:0]   count_n;
   logic               step_load, step_dec, step_zero, count_clr;
   logic               accept, bp_hit, stop_hit;
   logic [W_STEPS-1:0] steps_eff;

   assign accept    = cmd.cmd_valid && ready_q;
   // The first enabled cycle ignores the breakpoint so execution can resume from it.
   assign bp_hit    = bp_en && (pc_addr == bp_addr) && !first_q;
   assign stop_hit  = end_of_prog || bp_hit;
   assign steps_eff = (cmd.cmd_steps == '0) ? W_STEPS'(1) : cmd.cmd_steps;

   assign cmd.cmd_ready = ready_q;
   assign cmd.cmd_err   = err_q;

   step_counter #(.W(W_STEPS)) u_step_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (step_load),
      .load_val (steps_eff),
      .dec      (step_dec),
      .zero     (step_zero)
   );

   always_comb begin
      state_n   = state;
      cause_n   = stop_cause;
      done_n    = 1'b0;
      err_n     = 1'b0;
      first_n   = 1'b0;
      step_load = 1'b0;
      step_dec  = 1'b0;
      count_clr = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               unique case (cmd.cmd_op)
                  OP_RUN: begin
                     state_n = ST_RUN;
                     cause_n = CAUSE_NONE;
                     first_n = 1'b1;
                  end
                  OP_STEP: begin
                     state_n   = ST_STEP;
                     cause_n   = CAUSE_NONE;
                     first_n   = 1'b1;
                     step_load = 1'b1;
                  end
                  OP_RESTART: begin
                     state_n   = ST_RESTART;
                     cause_n   = CAUSE_NONE;
                     count_clr = 1'b1;
                  end
                  OP_HALT: cause_n = CAUSE_HALT;
               endcase
            end
         end
         ST_RUN, ST_STEP: begin
            step_dec = (state == ST_STEP);
            if (accept && (cmd.cmd_op == OP_HALT)) begin
               state_n = ST_IDLE;
               cause_n = CAUSE_HALT;
               done_n  = 1'b1;
            end else begin
               err_n = accept;
               if (stop_hit) begin
                  state_n = ST_IDLE;
                  cause_n = CAUSE_BREAK;
                  done_n  = 1'b1;
               end else if ((state == ST_STEP) && step_zero) begin
                  state_n = ST_IDLE;
                  cause_n = CAUSE_STEP;
                  done_n  = 1'b1;
               end
            end
         end
         ST_RESTART: state_n = ST_IDLE;
      endcase

      pc_enable_n = (state_n == ST_RUN) || (state_n == ST_STEP);
      pc_reset_n  = (state_n == ST_RESTART);
      ready_n     = (state_n != ST_RESTART);

      if (count_clr) begin
         count_n = '0;
      end else if (pc_enable && (cycle_count != '1)) begin
         count_n = cycle_count + 1'b1;
      end else begin
         count_n = cycle_count;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pc_enable   <= 1'b0;
         pc_reset    <= 1'b0;
         cycle_count <= '0;
         done        <= 1'b0;
         stop_cause  <= CAUSE_NONE;
         ready_q     <= 1'b1;
         err_q       <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         state       <= state_n;
         pc_enable   <= pc_enable_n;
         pc_reset    <= pc_reset_n;
         cycle_count <= count_n;
         done        <= done_n;
         stop_cause  <= cause_n;
         ready_q     <= ready_n;
         err_q       <= err_n;
         first_q     <= first_n;
      end
   end

endmodule
